cmd_arbiter: RTL

CMD_ARBITER -- requirements
Module: cmd_arbiter

---
 rtl/cmd_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/cmd_arbiter.sv
// Round-robin arbiter that hands one of four requesters' commands to a single master.
// Grant one edge after req is sampled; m_cmd follows one edge later; done/err pulse one edge after COMPLETE.
// Requesters are held off (inputs ignored) from selection until the completion cycle; master paced by m_state.
module cmd_arbiter #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic           clk,
   input  logic           a_rst,
   input  logic [3:0]     req,
   input  logic [31:0]    req_addr,
   input  logic [15:0]    req_ctrl,
   input  logic [479:0]   req_data,
   input  logic [3:0]     req_rw,
   output logic [3:0]     grant,
   output logic [3:0]     done,
   output logic           err,
   output logic [119:0]   rdata,
   output logic           m_cmd,
   output logic [7:0]     m_addr,
   output logic [3:0]     m_ctrl,
   output logic [119:0]   m_data,
   output logic           m_rw,
   input  logic [3:0]     m_state,
   input  logic [119:0]   m_answer
);

   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_ISSUE      = 3'd1;
   localparam logic [2:0] S_WAIT_START = 3'd2;
   localparam logic [2:0] S_WAIT_DONE  = 3'd3;
   localparam logic [2:0] S_COMPLETE   = 3'd4;

   localparam logic [7:0] TIMEOUT_VAL = 8'(TIMEOUT);

   logic [1:0] rst_q;
   logic       rst_i;
   logic [2:0] state;
   logic [1:0] ptr;
   logic [7:0] tcnt;
   logic       err_flag;
   logic       found;
   logic [1:0] win;
   logic [1:0] idx;
   logic [3:0] win_ctrl;

   // Reset asserts immediately but releases only after two clean clock edges
   always_ff @(posedge clk or posedge a_rst) begin
      if (a_rst) begin
         rst_q <= 2'b11;
      end else begin
         rst_q <= {rst_q[0], 1'b0};
      end
   end

   assign rst_i = rst_q[1];

   // Pick the first asserted request at or after the round-robin pointer
   always_comb begin
      found = 1'b0;
      win   = 2'd0;
      idx   = 2'd0;
      for (int k = 0; k < 4; k++) begin
         idx = ptr + 2'(k);
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   assign win_ctrl = req_ctrl[4*win +: 4];

   // Command sequencing: arbitrate, issue, track master progress, complete
   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         state    <= S_IDLE;
         ptr      <= 2'd0;
         tcnt     <= 8'd0;
         err_flag <= 1'b0;
         grant    <= 4'd0;
         done     <= 4'd0;
         err      <= 1'b0;
         rdata    <= '0;
         m_cmd    <= 1'b0;
         m_addr   <= 8'd0;
         m_ctrl   <= 4'd0;
         m_data   <= '0;
         m_rw     <= 1'b0;
      end else begin
         done <= 4'd0;
         err  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (found) begin
                  m_addr <= req_addr[8*win +: 8];
                  m_ctrl <= win_ctrl;
                  m_data <= req_data[120*win +: 120];
                  m_rw   <= req_rw[win];
                  grant  <= 4'b0001 << win;
                  ptr    <= win + 2'd1;
                  tcnt   <= 8'd0;
                  if (win_ctrl != 4'd0) begin
                     err_flag <= 1'b0;
                     state    <= S_ISSUE;
                  end else begin
                     // Zero-beat commands never reach the master
                     err_flag <= 1'b1;
                     state    <= S_COMPLETE;
                  end
               end
            end
            S_ISSUE: begin
               m_cmd <= 1'b1;
               state <= S_WAIT_START;
            end
            S_WAIT_START: begin
               // Timeout wins over the master starting in the same cycle
               if (tcnt == TIMEOUT_VAL) begin
                  m_cmd    <= 1'b0;
                  err_flag <= 1'b1;
                  state    <= S_COMPLETE;
               end else begin
                  tcnt <= tcnt + 8'd1;
                  if (m_state != 4'd0) begin
                     m_cmd <= 1'b0;
                     state <= S_WAIT_DONE;
                  end
               end
            end
            S_WAIT_DONE: begin
               if (tcnt == TIMEOUT_VAL) begin
                  m_cmd    <= 1'b0;
                  err_flag <= 1'b1;
                  state    <= S_COMPLETE;
               end else begin
                  tcnt <= tcnt + 8'd1;
                  if (m_state == 4'd0) begin
                     state <= S_COMPLETE;
                  end
               end
            end
            S_COMPLETE: begin
               done  <= grant;
               err   <= err_flag;
               grant <= 4'd0;
               // Only a successful read updates the captured result
               if (!m_rw && !err_flag) begin
                  rdata <= m_answer;
               end
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
